pressure_chamber: RTL

Closed-loop model and pump controller for the airlock chamber. Consumes the level commands startPressurizing / startDepressurizing and the door-closed flags from the departure/arrival workflow FSM. Ramps an 8-bit chamber pressure at a fixed tick rate and feeds it back to that FSM as pressure[7:0]. Enforces pump interlocks: no motion while a door is open or both commands are active.

---
 rtl/airlock_pkg.sv | 50 +++++
 rtl/pressure_chamber_tick_prescaler.sv | 33 +++
 rtl/pressure_chamber.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/airlock_pkg.sv
// Shared airlock definitions: chamber state encoding, pressure targets and the
// workflow FSM's pressure windows, plus the saturating pressure step helpers.
package airlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_PAUSE = 2'b11
    } chamber_state_t;

    localparam logic [7:0] HIGH_TARGET_DEF = 8'd100;
    localparam logic [7:0] LOW_TARGET_DEF  = 8'd0;

    // Workflow FSM thresholds: low means < 10, high window is 91..109.
    localparam logic [7:0] FSM_LOW_THRESH = 8'd10;
    localparam logic [7:0] FSM_HIGH_LO    = 8'd90;
    localparam logic [7:0] FSM_HIGH_HI    = 8'd110;

    function automatic logic [7:0] fill_step(input logic [7:0] p, input logic [7:0] step,
                                             input logic [7:0] high);
        logic [8:0] sum;
        sum = {1'b0, p} + {1'b0, step};
        if (sum >= {1'b0, high}) begin
            return high;
        end else begin
            return sum[7:0];
        end
    endfunction

    function automatic logic [7:0] drain_step(input logic [7:0] p, input logic [7:0] step,
                                              input logic [7:0] low);
        logic [8:0] floor_s;
        floor_s = {1'b0, low} + {1'b0, step};
        if ({1'b0, p} < floor_s) begin
            return low;
        end else begin
            return p - step;
        end
    endfunction

    function automatic logic in_high_window(input logic [7:0] p);
        return (p > FSM_HIGH_LO) && (p < FSM_HIGH_HI);
    endfunction

    function automatic logic in_low_window(input logic [7:0] p);
        return (p < FSM_LOW_THRESH);
    endfunction

endpackage

// File: rtl/pressure_chamber_tick_prescaler.sv
// Free-running divider that emits a one-cycle tick every TICK_DIV enabled cycles;
// clear has priority and restarts the count at zero.
module tick_prescaler #(
    parameter int TICK_DIV = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] TERM = W'(TICK_DIV - 1);

    logic [W-1:0] r_count;

    // Divider counter, wrapping at terminal count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= (r_count == TERM) ? '0 : r_count + W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign tick = enable & ~clear & (r_count == TERM);

endmodule

// File: rtl/pressure_chamber.sv
// Airlock chamber pump controller: ramps the chamber pressure toward the fill or
// drain target at the prescaler rate, pausing on open doors and stopping on conflict.
module pressure_chamber
    import airlock_pkg::*;
#(
    parameter int         TICK_DIV       = 16,
    parameter logic [7:0] STEP           = 8'd1,
    parameter logic [7:0] HIGH_TARGET    = HIGH_TARGET_DEF,
    parameter logic [7:0] LOW_TARGET     = LOW_TARGET_DEF,
    parameter logic [7:0] RESET_PRESSURE = 8'd100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       startPressurizing,
    input  logic       startDepressurizing,
    input  logic       odClosed,
    input  logic       idClosed,
    output logic [7:0] pressure,
    output logic       filling,
    output logic       draining,
    output logic       doorHold,
    output logic       cmdConflict
);

    chamber_state_t r_state;
    chamber_state_t w_state_next;
    logic           r_dir;
    logic           w_dir_next;
    logic [7:0]     r_pressure;
    logic [7:0]     w_pressure_next;
    logic           r_door_hold;
    logic           w_door_hold_next;
    logic           r_conflict;

    logic       w_conflict;
    logic       w_doors_ok;
    logic       w_run_cmd;
    logic       w_tick;
    logic       w_clear;
    logic       w_enable;
    logic [7:0] w_step_p;
    logic [7:0] w_target;

    assign w_conflict = startPressurizing & startDepressurizing;
    assign w_doors_ok = odClosed & idClosed;
    // r_dir remembers which command owns the ramp so PAUSE can resume the right way.
    assign w_run_cmd  = r_dir ? startPressurizing : startDepressurizing;
    assign w_enable   = (r_state == ST_FILL) | (r_state == ST_DRAIN);
    assign w_clear    = ~w_enable;
    assign w_step_p   = (r_state == ST_FILL) ? fill_step(r_pressure, STEP, HIGH_TARGET)
                                             : drain_step(r_pressure, STEP, LOW_TARGET);
    assign w_target   = (r_state == ST_FILL) ? HIGH_TARGET : LOW_TARGET;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_clear),
        .enable (w_enable),
        .tick   (w_tick)
    );

    // State and ramp direction registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_dir   <= w_dir_next;
        end
    end

    // Next-state, next-pressure and door-hold decision.
    always_comb begin
        w_state_next     = r_state;
        w_dir_next       = r_dir;
        w_pressure_next  = r_pressure;
        w_door_hold_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_conflict && w_doors_ok && startPressurizing && (r_pressure < HIGH_TARGET)) begin
                    w_state_next = ST_FILL;
                    w_dir_next   = 1'b1;
                end else if (!w_conflict && w_doors_ok && startDepressurizing &&
                             (r_pressure > LOW_TARGET)) begin
                    w_state_next = ST_DRAIN;
                    w_dir_next   = 1'b0;
                end else if (!w_conflict && !w_doors_ok &&
                             (startPressurizing || startDepressurizing)) begin
                    w_door_hold_next = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_FILL, ST_DRAIN: begin
                if (w_conflict || !w_run_cmd) begin
                    w_state_next = ST_IDLE;
                end else if (!w_doors_ok) begin
                    w_state_next     = ST_PAUSE;
                    w_door_hold_next = 1'b1;
                end else if (w_tick) begin
                    w_pressure_next = w_step_p;
                    if (w_step_p == w_target) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = r_state;
                    end
                end else begin
                    w_state_next = r_state;
                end
            end
            ST_PAUSE: begin
                if (w_conflict || !w_run_cmd) begin
                    w_state_next = ST_IDLE;
                end else if (w_doors_ok) begin
                    w_state_next = r_dir ? ST_FILL : ST_DRAIN;
                end else begin
                    w_door_hold_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Pressure and registered status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pressure  <= RESET_PRESSURE;
            r_door_hold <= 1'b0;
            r_conflict  <= 1'b0;
        end else begin
            r_pressure  <= w_pressure_next;
            r_door_hold <= w_door_hold_next;
            r_conflict  <= w_conflict;
        end
    end

    // Mode outputs decoded from the state register.
    always_comb begin
        filling  = (r_state == ST_FILL);
        draining = (r_state == ST_DRAIN);
    end

    assign pressure    = r_pressure;
    assign doorHold    = r_door_hold;
    assign cmdConflict = r_conflict;

endmodule
